// File: rtl/s2b_pkg.sv
// Shared types and constants for the stochastic-to-binary accumulator.
package s2b_pkg;

  localparam int unsigned S2B_DATAWD = 8;

  typedef enum logic [1:0] {
    S2B_IDLE = 2'd0,
    S2B_ACC  = 2'd1,
    S2B_DONE = 2'd2
  } s2b_state_t;

  // Window length in enabled cycles for a given resolution.
  function automatic int unsigned s2b_win_len(input int unsigned datawd);
    return 32'd1 << datawd;
  endfunction

endpackage

// File: rtl/s2b_win_cnt.sv
// Enabled-cycle window counter; tc flags the final (Nth) slot of the window.
module s2b_win_cnt
  import s2b_pkg::*;
#(
  parameter int unsigned DATAWD = S2B_DATAWD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc,
  output logic [DATAWD:0] len,
  output logic            tc
);

  localparam int unsigned     N    = s2b_win_len(DATAWD);
  localparam logic [DATAWD:0] LAST = (DATAWD+1)'(N - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len <= '0;
    end else if (clr) begin
      len <= '0;
    end else if (inc) begin
      len <= len + 1'b1;
    end
  end

  assign tc = (len == LAST);

endmodule

// File: rtl/s2b_acc.sv
// Stochastic-to-binary converter: counts 1s over 2^DATAWD enabled cycles.
// Optional S2B_ACC_SAT_EN clamps the reported count to 2^DATAWD-1.
module s2b_acc
  import s2b_pkg::*;
#(
  parameter int unsigned DATAWD = S2B_DATAWD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iStart,
  input  logic            iEn,
  input  logic            iBit,
  input  logic            iAck,
  output logic [DATAWD:0] oData,
  output logic            oValid,
  output logic            oBusy
);

  localparam int unsigned N = s2b_win_len(DATAWD);

  s2b_state_t      state;
  logic [DATAWD:0] cnt;
  logic [DATAWD:0] len;
  logic [DATAWD:0] cnt_nxt;
  logic [DATAWD:0] result;
  logic            tc;
  logic            win_inc;

  assign win_inc = (state == S2B_ACC) && iEn && !iStart;
  assign cnt_nxt = cnt + {{DATAWD{1'b0}}, iBit};

`ifdef S2B_ACC_SAT_EN
  localparam logic [DATAWD:0] SAT_MAX = (DATAWD+1)'(N - 1);
  assign result = (cnt_nxt > SAT_MAX) ? SAT_MAX : cnt_nxt;
`else
  assign result = cnt_nxt;
`endif

  s2b_win_cnt #(.DATAWD(DATAWD)) u_win_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (iStart),
    .inc   (win_inc),
    .len   (len),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S2B_IDLE;
      cnt   <= '0;
      oData <= '0;
    end else begin
      case (state)
        S2B_IDLE: begin
          if (iStart) begin
            state <= S2B_ACC;
            cnt   <= '0;
          end
        end
        S2B_ACC: begin
          if (iStart) begin
            cnt <= '0;
          end else if (iEn) begin
            cnt <= cnt_nxt;
            // Final enabled bit is folded into the published result.
            if (tc) begin
              state <= S2B_DONE;
              oData <= result;
            end
          end
        end
        S2B_DONE: begin
          if (iStart) begin
            state <= S2B_ACC;
            cnt   <= '0;
          end else if (iAck) begin
            state <= S2B_IDLE;
          end
        end
        default: state <= S2B_IDLE;
      endcase
    end
  end

  assign oBusy  = (state == S2B_ACC);
  assign oValid = (state == S2B_DONE);

endmodule

// File: tb/tb_s2b_acc.sv
// Scoreboard bench for s2b_acc: expected counts queued at window end, checked on oValid rise.
module tb_s2b_acc;

  localparam int unsigned DATAWD = 8;
  localparam int unsigned N      = 1 << DATAWD;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            iStart = 1'b0;
  logic            iEn = 1'b0;
  logic            iBit = 1'b0;
  logic            iAck = 1'b0;
  logic [DATAWD:0] oData;
  logic            oValid;
  logic            oBusy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned model_cnt = 0;
  int unsigned sb[$];
  logic        prev_valid = 1'b0;
  logic [DATAWD:0] held_data;

  s2b_acc #(.DATAWD(DATAWD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .iStart (iStart),
    .iEn    (iEn),
    .iBit   (iBit),
    .iAck   (iAck),
    .oData  (oData),
    .oValid (oValid),
    .oBusy  (oBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned exp_of(input int unsigned c);
`ifdef S2B_ACC_SAT_EN
    return (c > N - 1) ? N - 1 : c;
`else
    return c;
`endif
  endfunction

  // Scoreboard consumer: every oValid rise must match a queued window result.
  always @(negedge clk) begin
    if (oValid && !prev_valid) begin
      if (sb.size() == 0) check("unexpected_valid", 1, 0);
      else check("sb_data", oData, sb.pop_front());
    end
    prev_valid = oValid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic en, input logic b);
    iEn  = en;
    iBit = b;
    tick();
    if (en) model_cnt += b;
    iEn  = 1'b0;
    iBit = 1'b0;
  endtask

  task automatic start_win();
    iStart = 1'b1;
    iEn    = 1'b1;
    iBit   = 1'b1;
    tick();
    iStart = 1'b0;
    iEn    = 1'b0;
    iBit   = 1'b0;
    model_cnt = 0;
  endtask

  task automatic end_win();
    sb.push_back(exp_of(model_cnt));
  endtask

  task automatic ack();
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_data", oData, 0);
    check("rst_valid", oValid, 0);
    check("rst_busy", oBusy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Half density
    start_win();
    check("t1_busy", oBusy, 1);
    for (int i = 0; i < int'(N) - 1; i++) send_bit(1'b1, (i % 2) == 0);
    check("t1_pre_valid", oValid, 0);
    send_bit(1'b1, 1'b0);
    end_win();
    check("t1_valid_lat", oValid, 1);
    check("t1_busy_done", oBusy, 0);
    check("t1_model", model_cnt, 128);
    ack();
    check("t1_ack_valid", oValid, 0);
    check("t1_ack_busy", oBusy, 0);
    check("t1_data_kept", oData, 128);

    // All ones, then hold without ack
    start_win();
    for (int i = 0; i < int'(N); i++) send_bit(1'b1, 1'b1);
    end_win();
    held_data = oData;
    for (int i = 0; i < 10; i++) begin
      send_bit($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      check("hold_valid", oValid, 1);
      check("hold_data", oData, exp_of(N));
    end
    ack();
    check("t2_ack_valid", oValid, 0);
    check("t2_ack_busy", oBusy, 0);

    // Reset mid-window
    start_win();
    for (int i = 0; i < 50; i++) send_bit(1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_data", oData, 0);
    check("mrst_valid", oValid, 0);
    check("mrst_busy", oBusy, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) send_bit(1'b1, 1'b1);
    check("mrst_no_valid", oValid, 0);
    check("mrst_idle", oBusy, 0);

    // Gapped enable
    start_win();
    for (int i = 0; i < int'(N); i++) begin
      if (i == int'(N) - 1) check("t3_pre_valid", oValid, 0);
      send_bit(1'b1, 1'b1);
      if (i < 100) send_bit(1'b0, 1'b1);
    end
    end_win();
    check("t3_valid", oValid, 1);
    ack();

    // Restart mid-window
    start_win();
    for (int i = 0; i < 100; i++) send_bit(1'b1, 1'b1);
    iStart = 1'b1; iEn = 1'b1; iBit = 1'b1;
    tick();
    iStart = 1'b0; iEn = 1'b0; iBit = 1'b0;
    model_cnt = 0;
    check("t4_busy", oBusy, 1);
    for (int i = 0; i < int'(N); i++) send_bit(1'b1, 1'b0);
    end_win();
    check("t4_valid", oValid, 1);

    // iStart and iAck together in DONE: start wins
    iStart = 1'b1; iAck = 1'b1;
    tick();
    iStart = 1'b0; iAck = 1'b0;
    model_cnt = 0;
    check("t5_valid_off", oValid, 0);
    check("t5_busy", oBusy, 1);
    for (int i = 0; i < int'(N); i++) send_bit(1'b1, i < 64);
    end_win();
    check("t5_valid", oValid, 1);
    check("t5_data", oData, 64);
    ack();

    tick();
    tick();
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
